re_readout_capture: RTL
=======================

// Module: re_readout_capture
// PURPOSE
//   Receive side of the readout control interface: watches NRE_1/NRE_2/ADC/Expose
//   as driven by the exposure controller and captures the ADC result for each pixel.
//   Buffers samples in a small FIFO and presents them as a valid/ready pixel stream
//   tagged with row and index. Flags protocol violations and overflow.
//   Sits between the pixel-array ADC output and the downstream frame store.
// PARAMETERS
//   DATA_W       8   ADC sample width
//   FRAME_PIX    4   samples per frame (2 rows x 2 pixels)
//   IDX_W        2   width of Pix_index; must satisfy 2**IDX_W >= FRAME_PIX
//   FIFO_DEPTH   4   sample FIFO entries, power of two, >= 2
// PORTS
//   Clk          in   1        system clock, all logic on rising edge
//   Reset_n      in   1        asynchronous active-low reset
//   Init         in   1        sync clear: FSM->IDLE, FIFO flushed, sticky flags cleared
//   Expose       in   1        exposure window from controller, active high
//   NRE_1        in   1        row 1 read enable, active low
//   NRE_2        in   1        row 2 read enable, active low
//   ADC          in   1        conversion strobe, active high
//   Data_in      in   DATA_W   ADC result, stable while ADC high and on its falling edge
//   Pix_ready    in   1        downstream accepts Pix_* this cycle
//   Pix_valid    out  1        FIFO non-empty
//   Pix_data     out  DATA_W   head sample
//   Pix_row      out  1        0 = NRE_1 row, 1 = NRE_2 row
//   Pix_index    out  IDX_W    sample number within frame, 0..FRAME_PIX-1
//   Frame_done   out  1        one-cycle pulse when FRAME_PIX samples captured
//   Proto_err    out  1        sticky: bad strobe or aborted frame
//   Overflow     out  1        sticky: sample dropped, FIFO full
// BEHAVIOUR
//   - Reset_n low: all outputs 0, FSM IDLE, FIFO empty, counters 0, adc_q/expose_q 0.
//   - Inputs share Clk domain; no synchronisers. adc_q, expose_q = 1-cycle delayed copies.
//   - Strobe edge: adc_fall = adc_q & ~ADC. Expose edges likewise from expose_q.
//   - FSM states: IDLE, EXPOSE, READOUT, DONE.
//     IDLE    -> EXPOSE on Expose rise.
//     EXPOSE  -> READOUT on Expose fall; pix counter cleared to 0.
//     READOUT -> DONE when capture of sample FRAME_PIX-1 occurs.
//     READOUT -> EXPOSE on Expose rise (abort): Proto_err set, counter cleared,
//                samples already in FIFO retained.
//     DONE    -> IDLE next cycle; Frame_done = 1 for exactly that DONE cycle.
//   - Capture (READOUT only, on adc_fall): exactly one of NRE_1/NRE_2 low -> push
//     {Data_in, row, counter}; counter increments. Data_in sampled in the adc_fall cycle.
//   - Both NRE low or both high on adc_fall: no push, counter unchanged, Proto_err set.
//   - adc_fall outside READOUT: ignored, no flag.
//   - Latency: sample pushed on edge ending adc_fall cycle; Pix_valid high next cycle.
//   - Pop when Pix_valid & Pix_ready. Pix_* hold stable while Pix_valid & ~Pix_ready.
//   - Push and pop same cycle: both occur, occupancy unchanged (incl. when full).
//   - Push when full and no pop: sample dropped, counter still increments, Overflow set.
//   - FIFO pointers IDX by log2(FIFO_DEPTH), wrap modulo depth; count 0..FIFO_DEPTH.
//   - Pix_ready with Pix_valid low: no effect.
//   - Init has priority over every event in the same cycle; Proto_err/Overflow clear
//     only via Init or Reset_n. Reset_n asserted mid-frame: immediate return to reset state.
// TESTING
//   1 Nominal: Expose 10 cyc, 4 ADC pulses (NRE_1 x2, NRE_2 x2), Data 0x11,0x22,0x33,0x44,
//     Pix_ready=1 -> stream (0x11,r0,i0)(0x22,r0,i1)(0x33,r1,i2)(0x44,r1,i3),
//     Frame_done 1 cycle after 4th push, flags 0.
//   2 Backpressure: Pix_ready=0 through 5 captures -> first 4 buffered, 5th dropped,
//     Overflow=1; release -> 4 samples out in order, Pix_data stable while stalled.
//   3 Bad strobe: ADC pulse with NRE_1=NRE_2=0 in READOUT -> no push, Proto_err=1,
//     next valid capture gets index 0.
//   4 Abort: Expose rises after 2 captures -> Proto_err=1, FSM EXPOSE, next frame index 0.
//   5 Init mid-READOUT with 2 samples queued -> Pix_valid=0, flags 0, FSM IDLE next cycle.
//   6 Async Reset_n pulse between edges mid-frame -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/re_readout_capture.sv
// Readout capture: samples ADC data on strobe falls during READOUT and streams them out through a small FIFO.
// Sample is visible on Pix_valid one cycle after its strobe fall; a full FIFO without a pop drops the sample and sets Overflow.

module re_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Clr,
  input  logic         Push,
  input  logic         Pop,
  input  logic [W-1:0] Wr_dat,
  output logic [W-1:0] Rd_dat,
  output logic         Empty,
  output logic         Full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign Empty   = (count == '0);
  assign Full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = Pop & ~Empty;
  // A pop frees the head slot, so a push into a full FIFO still lands.
  assign do_push = Push & (~Full | do_pop);
  assign Rd_dat  = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (do_push && !Clr) mem[wr_ptr] <= Wr_dat;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module re_readout_capture #(
  parameter int DATA_W     = 8,
  parameter int FRAME_PIX  = 4,
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Init,
  input  logic              Expose,
  input  logic              NRE_1,
  input  logic              NRE_2,
  input  logic              ADC,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Pix_ready,
  output logic              Pix_valid,
  output logic [DATA_W-1:0] Pix_data,
  output logic              Pix_row,
  output logic [IDX_W-1:0]  Pix_index,
  output logic              Frame_done,
  output logic              Proto_err,
  output logic              Overflow
);
  typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_READOUT, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              row;
    logic [IDX_W-1:0]  idx;
  } sample_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] pix_cnt, cnt_nxt;
  logic             adc_q, expose_q;
  logic             adc_fall, exp_rise, exp_fall;
  logic             one_low;
  logic             capture, bad_strobe, abort;
  logic             fifo_empty, fifo_full, pop;
  sample_t          push_dat, head;

  assign adc_fall = adc_q & ~ADC;
  assign exp_rise = Expose & ~expose_q;
  assign exp_fall = expose_q & ~Expose;
  assign one_low  = NRE_1 ^ NRE_2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      adc_q    <= 1'b0;
      expose_q <= 1'b0;
    end else begin
      adc_q    <= ADC;
      expose_q <= Expose;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = pix_cnt;
    capture    = 1'b0;
    bad_strobe = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE:   if (exp_rise) state_nxt = S_EXPOSE;
      S_EXPOSE: if (exp_fall) begin
        state_nxt = S_READOUT;
        cnt_nxt   = '0;
      end
      S_READOUT: begin
        // A new exposure wins over a strobe landing in the same cycle.
        if (exp_rise) begin
          state_nxt = S_EXPOSE;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else if (adc_fall) begin
          if (one_low) begin
            capture = 1'b1;
            cnt_nxt = pix_cnt + 1'b1;
            if (pix_cnt == IDX_W'(FRAME_PIX - 1)) state_nxt = S_DONE;
          end else begin
            bad_strobe = 1'b1;
          end
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign pop      = ~fifo_empty & Pix_ready;
  assign push_dat = '{data: Data_in, row: NRE_1, idx: pix_cnt};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      Proto_err <= 1'b0;
      Overflow  <= 1'b0;
    end else if (Init) begin
      state     <= S_IDLE;
      pix_cnt   <= '0;
      Proto_err <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= cnt_nxt;
      if (bad_strobe || abort)            Proto_err <= 1'b1;
      if (capture && fifo_full && !pop)   Overflow  <= 1'b1;
    end
  end

  re_fifo #(.W($bits(sample_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clr     (Init),
    .Push    (capture),
    .Pop     (Pix_ready),
    .Wr_dat  (push_dat),
    .Rd_dat  (head),
    .Empty   (fifo_empty),
    .Full    (fifo_full)
  );

  // Payload is forced to zero when nothing is queued so stale entries never leak out.
  assign Pix_valid  = ~fifo_empty;
  assign Pix_data   = Pix_valid ? head.data : '0;
  assign Pix_row    = Pix_valid ? head.row  : 1'b0;
  assign Pix_index  = Pix_valid ? head.idx  : '0;
  assign Frame_done = (state == S_DONE);
endmodule
